// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants for the nibble-serial adder.
// FSM encodings and default slice geometry.
package nibble_serial_adder_pkg;

  localparam int NIB_DEF   = 4;
  localparam int WORDS_DEF = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

endpackage

// File: rtl/nibble_add4.sv
// Combinational NIB-bit ripple-carry slice.
// Built from full-adder cells.
module nibble_add4
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIB = NIB_DEF
) (
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           cin,
  output logic [NIB-1:0] s,
  output logic           cout
);

  logic [NIB:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIB; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NIB];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that sums one nibble per clock through a single
// ripple slice, carrying between nibbles in a register.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIB   = NIB_DEF,
  parameter int WORDS = WORDS_DEF,
  localparam int W    = NIB * WORDS,
  localparam int IW   = $clog2(WORDS)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  logic [1:0] state;
  logic [IW-1:0] idx;
  logic [WORDS-1:0][NIB-1:0] a_r;
  logic [WORDS-1:0][NIB-1:0] b_r;
  logic [WORDS-1:0][NIB-1:0] work;
  logic [WORDS-1:0][NIB-1:0] work_nx;
  logic c_r;
  logic [NIB-1:0] slice_s;
  logic slice_c;
  logic last;
  logic ovf_nx;

  nibble_add4 #(.NIB(NIB)) u_slice (
    .a    (a_r[idx]),
    .b    (b_r[idx]),
    .cin  (c_r),
    .s    (slice_s),
    .cout (slice_c)
  );

  assign last = (idx == IW'(WORDS - 1));

  // Final nibble is merged here so sum lands together with done.
  always_comb begin
    work_nx      = work;
    work_nx[idx] = slice_s;
  end

  assign ovf_nx = (a_r[WORDS-1][NIB-1] == b_r[WORDS-1][NIB-1])
               && (work_nx[WORDS-1][NIB-1] != a_r[WORDS-1][NIB-1]);

  assign busy = (state == RUN);
  assign done = (state == FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      c_r   <= 1'b0;
      work  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            c_r   <= cin;
            idx   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          work[idx] <= slice_s;
          c_r       <= slice_c;
          if (last) begin
            sum   <= work_nx;
            cout  <= slice_c;
            ovf   <= ovf_nx;
            state <= FIN;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (16-bit default).
// Vector table plus scoreboarded multi-cycle sequences.
module tb_nibble_serial_adder;

  localparam int W = 16;
  localparam int LAT = 5;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [W-1:0] a, b;
  logic cin;
  logic busy, done, cout, ovf;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  exp_t q[$];

  nibble_serial_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input logic ci);
    exp_t e;
    logic [W:0] t;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    e.s = t[W-1:0];
    e.co = t[W];
    e.ov = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_cnt++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: sum %h with empty queue", sum);
      end else begin
        e = q.pop_front();
        if ({sum, cout, ovf} !== {e.s, e.co, e.ov}) begin
          errors++;
          $display("FAIL result: got %h/%b/%b want %h/%b/%b",
                   sum, cout, ovf, e.s, e.co, e.ov);
        end
      end
    end
  end

  // Drive one start, then measure cycles until done.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input exp_t e);
    int cnt;
    @(negedge clk);
    a = x; b = y; cin = ci; start = 1'b1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    while (!done && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("latency", 32'(cnt), 32'(LAT));
  endtask

  vec_t tbl[7];
  exp_t e;
  int base;
  int cnt;
  logic [W-1:0] ba[6];
  logic [W-1:0] bb[6];

  initial begin
    tbl[0] = '{16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[3] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    tbl[4] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #22;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      e = '{tbl[i].s, tbl[i].co, tbl[i].ov};
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, e);
      @(negedge clk);
      chk("hold_sum", 32'(sum), 32'(tbl[i].s));
    end

    // Start while busy is ignored.
    base = done_cnt;
    @(negedge clk);
    a = 16'h0011; b = 16'h0022; cin = 1'b0; start = 1'b1;
    q.push_back(model(16'h0011, 16'h0022, 1'b0));
    @(negedge clk);
    start = 1'b0;
    chk("busy_run", 32'(busy), 32'd1);
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("drop_done_cnt", 32'(done_cnt - base), 32'd1);
    chk("drop_sum", 32'(sum), 32'h0033);
    chk("idle_busy", 32'(busy), 32'd0);

    // Back-to-back with start held high.
    for (int i = 0; i < 5; i++) begin
      ba[i] = 16'($urandom);
      bb[i] = 16'($urandom);
    end
    ba[5] = 16'h1111; bb[5] = 16'h2222;
    base = done_cnt;
    @(negedge clk);
    a = ba[0]; b = bb[0]; cin = 1'b0; start = 1'b1;
    q.push_back(model(ba[0], bb[0], 1'b0));
    for (int i = 1; i <= 6; i++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!done && cnt < 20);
      chk("b2b_interval", 32'(cnt), 32'(LAT));
      if (i < 6) begin
        a = ba[i]; b = bb[i];
        q.push_back(model(ba[i], bb[i], 1'b0));
      end else begin
        start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    chk("b2b_done_cnt", 32'(done_cnt - base), 32'd6);
    chk("b2b_last_sum", 32'(sum), 32'h3333);

    // Asynchronous reset during RUN at idx 2.
    base = done_cnt;
    @(negedge clk);
    a = 16'h0505; b = 16'h0A0A; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_sum", 32'(sum), 32'h3333);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_flags", 32'({cout, ovf}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - base), 32'd0);
    run_op(16'h0003, 16'h0004, 1'b0, model(16'h0003, 16'h0004, 1'b0));
    @(negedge clk);
    chk("post_rst_sum", 32'(sum), 32'h0007);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder built around one 4-bit ripple-carry slice.
- Operands are latched on a start strobe. One nibble per clock is summed, least significant nibble first. The carry is held in a register between nibbles.
- Sits directly downstream of the 4-bit ripple adder stage, which it consumes as its datapath. Gives the design wide additions without a wide combinational carry chain.

Parameters:
- NIB, 4, bits per slice (width of the ripple slice).
- WORDS, 4, number of nibbles per operand; operand width W = NIB*WORDS (16 by default). Legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new addition; sampled on rising clk
- a  input  W  operand A; sampled only on an accepted start
- b  input  W  operand B; sampled only on an accepted start
- cin  input  1  carry-in; sampled only on an accepted start
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse when sum/cout/ovf become valid
- sum  output  W  registered result, held until the next completion
- cout  output  1  carry out of the MSB nibble, registered with sum
- ovf  output  1  two's-complement overflow, registered with sum

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; index, carry and operand registers cleared. Reset mid-operation aborts the addition immediately; no done is produced.
- FSM states:
  - IDLE: start=1 -> latch a, b, cin into A_r, B_r, C_r; idx=0; go to RUN.
  - RUN: each cycle, slice inputs are A_r[idx], B_r[idx] and C_r. Slice sum is written to work nibble idx. C_r <= slice cout. idx <= idx+1. When idx==WORDS-1, go to FIN.
  - FIN: sum <= work, cout <= C_r, ovf <= (A_r[W-1]==B_r[W-1]) && (work[W-1]!=A_r[W-1]); done=1 for this one cycle.
    - start=1 in FIN -> relatch operands, go to RUN (back-to-back, no bubble).
    - otherwise go to IDLE.
- busy=1 in RUN and FIN's predecessor cycles only, i.e. busy = (state==RUN); done = (state==FIN); both are registered state decodes.
- Latency: start accepted at edge k. RUN occupies cycles k+1..k+WORDS. done and the updated sum are visible in cycle k+WORDS+1 (5 cycles after start for WORDS=4). Throughput is one result per WORDS+1 cycles.
- start while in RUN is ignored; it is neither queued nor used to relatch operands.
- sum, cout and ovf change only on FIN entry. They hold their value through subsequent IDLE and RUN.
- Arithmetic is unsigned modulo 2^W; cout is the true carry. ovf interprets the operands as signed. cin participates in the sum but not in the ovf sign test beyond its effect on work[W-1].
- idx width = clog2(WORDS); idx never exceeds WORDS-1 and wraps to 0 on relatch.

Decomposition:
- Shared package/header: FSM state encodings (IDLE=2'd0, RUN=2'd1, FIN=2'd2) and the default NIB/WORDS constants.
- One sub-module: nibble_add4, a combinational NIB-bit ripple-carry slice (a, b, cin -> s, cout) built from full-adder cells. It is instantiated once. Nibble select and work-register writeback live in the top.

Test Plan:
- Wrap: a=0x0001, b=0xFFFF, cin=0 -> done 5 cycles after start; sum=0x0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Carry-in and inter-nibble carry: a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0. Also a=0x0FFF, b=0x0001, cin=0 -> sum=0x1000, exercising a carry across 3 nibbles.
- Start during busy: start a=0x0011, b=0x0022; pulse start with a=0xFFFF, b=0xFFFF at cycle 2 -> result 0x0033, a single done, and the second request is dropped.
- Back-to-back: start held high continuously with new operands each acceptance -> done every 5 cycles; sum sequence matches a reference model; no missed or duplicated done.
- Reset mid-op: assert rst_n=0 during RUN (idx=2) -> busy, done, sum, cout and ovf go to 0 asynchronously. After release, a fresh start a=0x0003, b=0x0004 gives sum=0x0007.
